// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  // state | meaning
  // IDLE  | waiting for start, results held
  // CALC  | WIDTH shift-add / restoring-divide iterations
  // FIX   | sign correction and divide-by-zero override
  // DONE  | one-cycle done pulse, results valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiplier / restoring divider sharing one shift register
// and one adder/subtractor; signs are handled on magnitudes and fixed at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             div_reg;
  logic             sgn_reg;

  // Magnitude is formed at WIDTH+1 bits so the most-negative value is exact;
  // the result always fits back into WIDTH bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH:0] ext;
    logic [WIDTH:0] m;
    ext = {sgn & v[WIDTH-1], v};
    m   = ext[WIDTH] ? -ext : ext;
    return m[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] in_mag_a, in_mag_b, mag_a, mag_b;
  assign in_mag_a = mag(src_a, op_signed);
  assign in_mag_b = mag(src_b, op_signed);
  assign mag_a    = mag(a_reg, sgn_reg);
  assign mag_b    = mag(b_reg, sgn_reg);

  logic [AW-1:0]    shl;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_cin;
  logic [WIDTH+1:0] sum;
  logic [AW-1:0]    acc_next;

  assign shl = {acc[AW-2:0], 1'b0};

  // Divide subtracts via x + ~y + 1; the carry out means the trial fits.
  always_comb begin
    add_x   = acc[AW-1:WIDTH];
    add_y   = acc[0] ? {1'b0, mag_a} : '0;
    add_cin = 1'b0;
    if (div_reg == OP_DIV) begin
      add_x   = shl[AW-1:WIDTH];
      add_y   = ~{1'b0, mag_b};
      add_cin = 1'b1;
    end
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, add_cin};

  always_comb begin
    acc_next = {1'b0, sum[WIDTH:0], acc[WIDTH-1:1]};
    if (div_reg == OP_DIV)
      acc_next = sum[WIDTH+1] ? {sum[WIDTH:0], shl[WIDTH-1:1], 1'b1} : shl;
  end

  logic                 neg;
  logic [2*WIDTH-1:0]   prod, prod_fix;
  logic [WIDTH-1:0]     quo, rem, quo_fix, rem_fix;
  logic                 b_zero;

  assign neg      = sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
  assign prod     = acc[2*WIDTH-1:0];
  assign prod_fix = neg ? -prod : prod;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg ? -quo : quo;
  assign rem_fix  = (sgn_reg & a_reg[WIDTH-1]) ? -rem : rem;
  assign b_zero   = (b_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      div_reg  <= OP_MUL;
      sgn_reg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !cancel) begin
            a_reg   <= src_a;
            b_reg   <= src_b;
            div_reg <= op_div;
            sgn_reg <= op_signed;
            acc     <= {{(WIDTH + 1){1'b0}}, (op_div == OP_DIV) ? in_mag_a : in_mag_b};
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= FIX;
          end
        end
        FIX: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (div_reg == OP_MUL) begin
              hi       <= prod_fix[2*WIDTH-1:WIDTH];
              lo       <= prod_fix[WIDTH-1:0];
              div_zero <= 1'b0;
            end else if (b_zero) begin
              hi       <= a_reg;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              hi       <= rem_fix;
              lo       <= quo_fix;
              div_zero <= 1'b0;
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, op_div, op_signed, cancel;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, done, div_zero;

  logic       reset8, start8, op_div8, op_signed8, cancel8;
  logic [7:0] src_a8, src_b8, hi8, lo8;
  logic       busy8, done8, div_zero8;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .op_signed(op_signed),
    .cancel(cancel), .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .op_div(op_div8), .op_signed(op_signed8),
    .cancel(cancel8), .src_a(src_a8), .src_b(src_b8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .div_zero(div_zero8)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic d, input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
    res_t        r;
    logic [63:0] p;
    longint      sa, sb_v, q, m;
    r.dz = 1'b0;
    if (d == OP_MUL) begin
      if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      else   p = {32'b0, a} * {32'b0, b};
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 32'd0) begin
      r.hi = a;
      r.lo = '1;
      r.dz = 1'b1;
    end else begin
      if (s) begin
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
      end else begin
        sa   = longint'({32'b0, a});
        sb_v = longint'({32'b0, b});
      end
      q    = sa / sb_v;
      m    = sa % sb_v;
      r.lo = q[31:0];
      r.hi = m[31:0];
    end
    return r;
  endfunction

  task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    op_div = d; op_signed = s; src_a = a; src_b = b; start = 1'b1;
    if (push) sb.push_back(model(d, s, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int   cyc;
    res_t e;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd34);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: observed result with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
      check({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
      check({tag, "_dz"}, {63'b0, div_zero}, {63'b0, e.dz});
    end
    @(posedge clk); #1;
    check({tag, "_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] prev_hi, prev_lo;
    int          cyc8;

    reset = 1'b1; start = 1'b0; op_div = 1'b0; op_signed = 1'b0; cancel = 1'b0;
    src_a = '0; src_b = '0;
    reset8 = 1'b1; start8 = 1'b0; op_div8 = 1'b0; op_signed8 = 1'b0; cancel8 = 1'b0;
    src_a8 = '0; src_b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; reset8 = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_dz", {63'b0, div_zero}, 64'd0);

    // Directed cases
    issue(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("umul_max");
    issue(OP_MUL, 1'b1, -32'sd3, 32'sd7, 1'b1);              wait_done("smul_m3x7");
    issue(OP_DIV, 1'b1, -32'sd7, 32'sd2, 1'b1);              wait_done("sdiv_m7d2");
    issue(OP_DIV, 1'b0, 32'd5, 32'd0, 1'b1);                 wait_done("udiv_5d0");
    issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done("sdiv_min");
    issue(OP_DIV, 1'b1, -32'sd5, 32'd0, 1'b1);               wait_done("sdiv_m5d0");
    issue(OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);         wait_done("udiv_max1");

    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            $urandom >> $urandom_range(0, 31), 1'b1);
      wait_done("rand");
    end

    // Start while busy must not re-latch operands
    issue(OP_MUL, 1'b0, 32'd1234, 32'd5678, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    src_a = 32'd99; src_b = 32'd77; op_div = OP_DIV; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    begin
      int cyc;
      res_t e;
      cyc = 8;
      while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check("ignore_lat", 64'(cyc), 64'd34);
      e = sb.pop_front();
      check("ignore_hi", {32'b0, hi}, {32'b0, e.hi});
      check("ignore_lo", {32'b0, lo}, {32'b0, e.lo});
      @(posedge clk); #1;
    end

    // Cancel beats start in IDLE
    cancel = 1'b1; start = 1'b1; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    check("prio_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("prio_busy2", {63'b0, busy}, 64'd0);
    check("prio_done", {63'b0, done}, 64'd0);

    // Cancel in cycle 10 of a divide, restart on the next cycle
    prev_hi = hi; prev_lo = lo;
    issue(OP_DIV, 1'b0, 32'd1000, 32'd7, 1'b0);
    seen = 1'b0;
    repeat (9) begin @(posedge clk); #1; seen |= done; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", {63'b0, busy}, 64'd0);
    check("cancel_done", {63'b0, done | seen}, 64'd0);
    check("cancel_hold_hi", {32'b0, hi}, {32'b0, prev_hi});
    check("cancel_hold_lo", {32'b0, lo}, {32'b0, prev_lo});
    issue(OP_DIV, 1'b1, -32'sd100, 32'sd9, 1'b1);
    check("restart_hold_lo", {32'b0, lo}, {32'b0, prev_lo});
    wait_done("restart");

    // Cancel in FIX
    prev_lo = lo;
    issue(OP_MUL, 1'b0, 32'd6, 32'd7, 1'b0);
    repeat (32) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cfix_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("cfix_done", {63'b0, done}, 64'd0);
    check("cfix_hold_lo", {32'b0, lo}, {32'b0, prev_lo});

    // Asynchronous reset mid-CALC
    issue(OP_MUL, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_hi", {32'b0, hi}, 64'd0);
    check("arst_lo", {32'b0, lo}, 64'd0);
    check("arst_dz", {63'b0, div_zero}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= done; end
    check("arst_no_done", {63'b0, seen}, 64'd0);
    issue(OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done("post_rst");

    // WIDTH=8 instance
    op_div8 = OP_MUL; op_signed8 = 1'b0; src_a8 = 8'hFF; src_b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc8 = 1;
    while (!done8 && cyc8 < 40) begin @(posedge clk); #1; cyc8++; end
    check("w8_lat", 64'(cyc8), 64'd10);
    check("w8_hi", {56'b0, hi8}, 64'hFE);
    check("w8_lo", {56'b0, lo8}, 64'h01);
    @(posedge clk); #1;
    op_div8 = OP_DIV; op_signed8 = 1'b1; src_a8 = 8'h80; src_b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 reset8 = 1'b1;
    #1;
    check("w8_arst_busy", {63'b0, busy8}, 64'd0);
    check("w8_arst_hi", {56'b0, hi8}, 64'd0);
    check("w8_arst_lo", {56'b0, lo8}, 64'd0);
    @(posedge clk); #1;
    reset8 = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; seen |= done8; end
    check("w8_no_done", {63'b0, seen}, 64'd0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left: observed %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning operand width in bits (legal values are even numbers 8..64).
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL provide port op_div  input  1  operation select: 1 = divide, 0 = multiply.
REQ-006 SHALL provide port op_signed  input  1  operand encoding: 1 = two's complement, 0 = unsigned.
REQ-007 SHALL provide port cancel  input  1  abort the operation in flight (pipeline flush or exception).
REQ-008 SHALL provide ports src_a, src_b  input  WIDTH  operands; src_a is the multiplicand or dividend, src_b the multiplier or divisor.
REQ-009 SHALL provide port busy  output  1  high while an operation is in flight.
REQ-010 SHALL provide port done  output  1  one-cycle pulse that marks hi/lo/div_zero as valid.
REQ-011 SHALL provide ports hi, lo  output  WIDTH  results; multiply gives the product upper/lower halves, divide gives remainder (hi) and quotient (lo).
REQ-012 SHALL provide port div_zero  output  1  set when the completed divide had src_b == 0.

Function
REQ-013 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start in IDLE when cancel is low: latch the operands, op_div and op_signed, then move to CALC; busy rises on the following cycle.
REQ-015 SHALL ignore start in CALC, FIX and DONE; the operands are not re-latched.
REQ-016 SHALL run exactly WIDTH iterations in CALC, counted by a counter of ceil(log2(WIDTH+1)) bits.
REQ-017 SHALL compute multiply as radix-2 shift-add on the operand magnitudes.
REQ-018 SHALL compute divide as restoring division on the operand magnitudes.
REQ-019 SHALL, in FIX, apply sign correction when op_signed is high:
  - product negated if sign(a) != sign(b);
  - quotient negated if sign(a) != sign(b);
  - remainder takes the sign of a.
REQ-020 SHALL compute magnitudes at WIDTH+1 bits, so that the most-negative operand is exact.
REQ-021 SHALL, for signed MIN / -1, produce lo = MIN and hi = 0, with no flag.
REQ-022 SHALL, for divide by zero, produce lo = all ones, hi = src_a and div_zero = 1, with normal latency.
REQ-023 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE; busy goes low in the same cycle that done is high.
REQ-024 SHALL assert done in the (WIDTH+2)th cycle after the start-accept cycle (34 for WIDTH=32).
REQ-025 SHALL update hi, lo and div_zero only when entering DONE, and hold them until the next DONE or reset.
REQ-026 SHALL, when cancel is high in CALC or FIX, return to IDLE at the next edge with no done pulse; hi/lo/div_zero keep their previous values.
REQ-027 SHALL treat cancel in DONE as having no effect on the done pulse.
REQ-028 SHALL give cancel priority over start when both are high in IDLE; nothing is accepted.
REQ-029 SHALL allow a start to be accepted in the IDLE cycle immediately after DONE, or after a cancel.

Reset
REQ-030 SHALL, on reset assertion (asynchronous), force state IDLE, clear the counter and drive busy = 0, done = 0, hi = 0, lo = 0, div_zero = 0.
REQ-031 SHALL abort any operation in flight when reset is asserted, producing no done pulse after reset is released.
REQ-032 SHALL release reset without glitching done.

Structure
REQ-033 SHALL place the state enumeration and the op encodings (OP_MUL, OP_DIV) in the shared package muldiv_pkg.
REQ-034 SHALL be a single module with no sub-module; the datapath is one WIDTH*2+1 bit shift register plus one WIDTH+1 bit adder/subtractor, shared by multiply and divide.
REQ-035 SHALL replace the vendor multiplier/divider IP in the execute stage; the execute stage holds EXE_over low while busy is high or until done.

Verification
REQ-036 SHALL cover, at WIDTH=32: unsigned mul 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at cycle 34.
REQ-037 SHALL cover signed mul -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-038 SHALL cover signed div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-039 SHALL cover div 5 / 0 -> lo=0xFFFFFFFF, hi=0x00000005, div_zero=1; and signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 SHALL cover cancel at cycle 10 of a divide -> no done, busy low next cycle; a start in the following cycle completes correctly and earlier results are retained until then.
REQ-041 SHALL cover reset asserted mid-CALC -> all outputs 0 immediately, no done after release; repeat at WIDTH=8 with 0xFF x 0xFF unsigned -> hi=0xFE, lo=0x01, done at cycle 10.
